// File: rtl/inv_trans_divider.sv
// Reciprocal unit: inv_trans = min(floor(N / max(trans, T_MIN)), INV_MAX) in Q2.8, sat flags the clamp.
// Latency: out_valid rises 17 clock edges after the accept edge; one result per 19 cycles unthrottled.
// Backpressure: in_ready only in IDLE; the result is held in DONE until out_ready.
// Build option: define INV_TRANS_ROUND_EN for round-to-nearest (N = 2^16 + d/2); otherwise truncation (N = 2^16).
module inv_trans_divider #(
  parameter int T_MIN   = 64,
  parameter int INV_MAX = 1023
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [7:0] trans,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [9:0] inv_trans,
  output logic       sat
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [7:0]  TMIN8      = T_MIN[7:0];
  localparam logic [9:0]  INV_MAX10  = INV_MAX[9:0];
  localparam logic [16:0] INV_MAX17  = 17'(INV_MAX);
  localparam logic [16:0] N_BASE     = 17'h10000;
  localparam logic [4:0]  LAST_STEP  = 5'd16;

  state_t      state_q;
  logic [7:0]  d_q;        // clamped divisor
  logic [16:0] n_q;        // dividend, shifted left one bit per step
  logic [7:0]  rem_q;      // partial remainder, always < d
  logic [16:0] quo_q;      // quotient bits collected MSB first
  logic [4:0]  cnt_q;      // step index 0..16
  logic        in_ready_q;
  logic        out_valid_q;
  logic [9:0]  inv_q;
  logic        sat_q;

  logic [7:0]  d_d;
  logic [16:0] n_d;
  logic [8:0]  rem_sh;
  logic        q_bit;
  logic [7:0]  rem_d;
  logic [16:0] quo_d;

  // Operand setup for an accept, and one restoring step on the current state
  always_comb begin
    d_d = (trans < TMIN8) ? TMIN8 : trans;
`ifdef INV_TRANS_ROUND_EN
    n_d = N_BASE + {10'd0, d_d[7:1]};
`else
    n_d = N_BASE;
`endif
    rem_sh = {rem_q, n_q[16]};
    q_bit  = (rem_sh >= {1'b0, d_q});
    rem_d  = q_bit ? 8'(rem_sh - {1'b0, d_q}) : rem_sh[7:0];
    quo_d  = {quo_q[15:0], q_bit};
  end

  // Control FSM with registered handshake and result outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      d_q         <= '0;
      n_q         <= '0;
      rem_q       <= '0;
      quo_q       <= '0;
      cnt_q       <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      inv_q       <= '0;
      sat_q       <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid && in_ready_q) begin
            d_q        <= d_d;
            n_q        <= n_d;
            rem_q      <= '0;
            quo_q      <= '0;
            cnt_q      <= '0;
            in_ready_q <= 1'b0;
            state_q    <= CALC;
          end
        end
        CALC: begin
          rem_q <= rem_d;
          quo_q <= quo_d;
          n_q   <= {n_q[15:0], 1'b0};
          cnt_q <= 5'(cnt_q + 5'd1);
          if (cnt_q == LAST_STEP) begin
            // quo_d holds the complete 17-bit quotient on the final step
            inv_q       <= (quo_d > INV_MAX17) ? INV_MAX10 : quo_d[9:0];
            sat_q       <= (quo_d > INV_MAX17);
            out_valid_q <= 1'b1;
            state_q     <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state_q     <= IDLE;
          end
        end
        default: begin
          state_q     <= IDLE;
          in_ready_q  <= 1'b1;
          out_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign inv_trans = inv_q;
  assign sat       = sat_q;

endmodule

// File: tb/tb_inv_trans_divider.sv
// Directed and random bench for inv_trans_divider with an expected-result queue.
// Inputs are driven and outputs sampled on the falling edge.
// Results are compared on the out_valid/out_ready handshake, with stalls checked for stability.
module tb_inv_trans_divider;

  localparam int T_MIN = 64;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] trans;
  logic       out_valid;
  logic       out_ready;
  logic [9:0] inv_trans;
  logic       sat;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int acc_cyc = 0;

  logic [10:0] exp_q[$];   // {sat, inv_trans}

  inv_trans_divider #(.T_MIN(T_MIN), .INV_MAX(1023)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .trans     (trans),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .inv_trans (inv_trans),
    .sat       (sat)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic logic [10:0] golden(input logic [7:0] t);
    int d, n, q;
    logic [9:0] lo;
    d = (int'(t) < T_MIN) ? T_MIN : int'(t);
    n = 65536;
`ifdef INV_TRANS_ROUND_EN
    n = n + d / 2;
`endif
    q = n / d;
    if (q > 1023) return {1'b1, 10'd1023};
    lo = q[9:0];
    return {1'b0, lo};
  endfunction

  // Present t, wait for acceptance, push the expected result, then drop in_valid.
  task automatic send(input logic [7:0] t, input logic [10:0] exp);
    int n = 0;
    in_valid = 1'b1;
    trans    = t;
    while (!in_ready && n < 60) begin
      @(negedge clk);
      n++;
    end
    chk("accept_seen", 32'(in_ready), 32'd1);
    exp_q.push_back(exp);
    acc_cyc = cyc + 1;
    @(negedge clk);
    in_valid = 1'b0;
    trans    = 8'($urandom);
  endtask

  // Wait for a result, optionally check latency, stall, then handshake and compare.
  task automatic recv(input int stall, input bit lat_chk);
    int n = 0;
    logic [10:0] e;
    out_ready = 1'b0;
    while (!out_valid && n < 60) begin
      @(negedge clk);
      n++;
    end
    chk("out_valid_seen", 32'(out_valid), 32'd1);
    if (lat_chk) chk("latency", 32'(cyc - acc_cyc), 32'd17);
    if (exp_q.size() == 0) begin
      chk("queue_nonempty", 32'd0, 32'd1);
      e = '0;
    end else begin
      e = exp_q.pop_front();
    end
    for (int k = 0; k < stall; k++) begin
      chk("stall_valid", 32'(out_valid), 32'd1);
      chk("stall_inv", 32'(inv_trans), 32'(e[9:0]));
      chk("stall_sat", 32'(sat), 32'(e[10]));
      chk("stall_in_ready", 32'(in_ready), 32'd0);
      @(negedge clk);
    end
    chk("out_valid", 32'(out_valid), 32'd1);
    chk("inv_trans", 32'(inv_trans), 32'(e[9:0]));
    chk("sat", 32'(sat), 32'(e[10]));
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk("valid_drop", 32'(out_valid), 32'd0);
  endtask

  initial begin
    logic [7:0] t;
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    trans     = 8'd0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_inv", 32'(inv_trans), 32'd0);
    chk("rst_sat", 32'(sat), 32'd0);

    // Exact power of two
    send(8'd128, {1'b0, 10'd512});
    recv(0, 1'b1);

    // Rounding-sensitive and near-unity divisors
`ifdef INV_TRANS_ROUND_EN
    send(8'd200, {1'b0, 10'd328});
`else
    send(8'd200, {1'b0, 10'd327});
`endif
    recv(0, 1'b1);
    send(8'd255, {1'b0, 10'd257});
    recv(0, 1'b1);

    // Saturation at the clamp and for zero
    send(8'd64, {1'b1, 10'd1023});
    recv(0, 1'b1);
    send(8'd0, {1'b1, 10'd1023});
    recv(0, 1'b1);
    send(8'd10, {1'b1, 10'd1023});
    recv(1, 1'b1);

    // Backpressure in DONE with the next request already waiting
    send(8'd50, {1'b1, 10'd1023});
    in_valid = 1'b1;
    trans    = 8'd100;
    recv(5, 1'b1);
    chk("bp_in_ready", 32'(in_ready), 32'd1);
    send(8'd100, {1'b0, 10'd655});
    recv(0, 1'b1);

    // Reset in the middle of a calculation
    send(8'd200, golden(8'd200));
    repeat (7) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    void'(exp_q.pop_back());
    chk("abort_out_valid", 32'(out_valid), 32'd0);
    chk("abort_in_ready", 32'(in_ready), 32'd1);
    chk("abort_inv", 32'(inv_trans), 32'd0);
    chk("abort_sat", 32'(sat), 32'd0);
    send(8'd128, {1'b0, 10'd512});
    recv(0, 1'b1);

    // Full sweep, back to back, random downstream stalls
    for (int i = 0; i < 256; i++) begin
      t = 8'(i);
      send(t, golden(t));
      recv(int'($urandom_range(0, 3)), 1'b1);
    end

    chk("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
